// File: rtl/spi_master_nss.sv
// spi_master_nss: SPI master, MSB-first DATA_WIDTH frames, NUM_SS selects, runtime CPOL/CPHA, divided clock; SPI_LOOPBACK_EN feeds MOSI back as MISO.
// Latency: handshake to rx_valid = (2*DATA_WIDTH+2)*(cfg_div+1)+1 clk cycles.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is ignored, nothing is queued.
module spi_master_nss #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SS     = 2,
    parameter int DIV_WIDTH  = 16,
    localparam int SS_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic [SS_W-1:0]       cfg_ss_sel,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic [NUM_SS-1:0]     spi_ss_n
);
    localparam int NTOG = 2 * DATA_WIDTH;
    localparam int TW   = $clog2(NTOG + 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
    state_t state_q, state_d;

    logic [DIV_WIDTH-1:0]  div_q, div_cnt_q;
    logic                  cpol_q, cpha_q;
    logic [TW-1:0]         tog_cnt_q;
    logic [DATA_WIDTH-1:0] tx_sh_q, rx_sh_q;
    logic [NUM_SS-1:0]     ss_dec;
    logic                  miso_int;
    logic                  start, tick, leading, last_tog;
    logic                  do_toggle, do_sample, do_shift, frame_end;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign miso_int    = spi_mosi;
`else
    logic miso_s1, miso_s2;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= spi_miso;
            miso_s2 <= miso_s1;
        end
    end
    assign miso_int = miso_s2;
`endif

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign start    = tx_valid && tx_ready;
    assign tick     = (div_cnt_q == div_q);
    assign leading  = ~tog_cnt_q[0];
    assign last_tog = (tog_cnt_q == TW'(NTOG - 1));

    // Out-of-range selects decode to no line at all.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (cfg_ss_sel == SS_W'(i)) ss_dec[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        do_toggle = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = SETUP;
            SETUP: if (tick) state_d = XFER;
            XFER: begin
                if (tick) begin
                    do_toggle = 1'b1;
                    if (last_tog) state_d = HOLD;
                end
            end
            HOLD: begin
                if (tick) begin
                    frame_end = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // CPHA=0 samples on leading toggles; CPHA=1 on trailing ones.
    assign do_sample = do_toggle && (leading ^ cpha_q);
    assign do_shift  = do_toggle && (cpha_q ? leading : (!leading && !last_tog));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            div_cnt_q <= '0;
            tog_cnt_q <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_ss_n  <= '1;
        end else begin
            rx_valid <= 1'b0;
            if (state_q == IDLE || tick) div_cnt_q <= '0;
            else                         div_cnt_q <= div_cnt_q + 1'b1;

            if (start) begin
                div_q     <= cfg_div;
                cpol_q    <= cfg_cpol;
                cpha_q    <= cfg_cpha;
                tog_cnt_q <= '0;
                rx_sh_q   <= '0;
                spi_clk   <= cfg_cpol;
                spi_mosi  <= tx_data[DATA_WIDTH-1];
                spi_ss_n  <= ss_dec;
                // CPHA=0 has already put the MSB out, so pre-advance the shifter.
                tx_sh_q   <= cfg_cpha ? tx_data : {tx_data[DATA_WIDTH-2:0], 1'b0};
            end

            if (do_toggle) begin
                spi_clk   <= ~spi_clk;
                tog_cnt_q <= tog_cnt_q + 1'b1;
            end

            if (do_shift) begin
                spi_mosi <= tx_sh_q[DATA_WIDTH-1];
                tx_sh_q  <= {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
            end

            if (do_sample) rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], miso_int};

            if (frame_end) begin
                spi_ss_n <= '1;
                rx_data  <= rx_sh_q;
                rx_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_nss.sv
// Bench for spi_master_nss: table of frames in all modes plus reset-abort and back-to-back sequences.
// A second instance with three selects exercises the out-of-range select.
module tb_spi_master_nss;
`ifdef SPI_LOOPBACK_EN
    localparam int DW = 16;
`else
    localparam int DW = 8;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [15:0]   cfg_div = '0;
    logic          cfg_cpol = 1'b0, cfg_cpha = 1'b0;
    logic          cfg_ss_sel = 1'b0;
    logic [1:0]    cfg_ss_sel3 = '0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          spi_miso = 1'b0;

    logic          a_tx_ready, a_rx_valid, a_busy, a_clk, a_mosi;
    logic [DW-1:0] a_rx_data;
    logic [1:0]    a_ss_n;
    logic          b_tx_ready, b_rx_valid, b_busy, b_clk, b_mosi;
    logic [DW-1:0] b_rx_data;
    logic [2:0]    b_ss_n;

    always #5 clk = ~clk;

    spi_master_nss #(.DATA_WIDTH(DW), .NUM_SS(2), .DIV_WIDTH(16)) u_dut (
        .clk(clk), .resetn(resetn), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_ss_sel(cfg_ss_sel), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(a_tx_ready),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .busy(a_busy), .spi_clk(a_clk),
        .spi_mosi(a_mosi), .spi_miso(spi_miso), .spi_ss_n(a_ss_n));

    spi_master_nss #(.DATA_WIDTH(DW), .NUM_SS(3), .DIV_WIDTH(16)) u_dut3 (
        .clk(clk), .resetn(resetn), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .cfg_ss_sel(cfg_ss_sel3), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(b_tx_ready),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy), .spi_clk(b_clk),
        .spi_mosi(b_mosi), .spi_miso(spi_miso), .spi_ss_n(b_ss_n));

    typedef struct {
        logic          cpol;
        logic          cpha;
        logic [15:0]   div;
        logic          sel;
        logic [1:0]    sel3;
        logic [DW-1:0] tx;
        logic [DW-1:0] miso;
        logic [DW-1:0] exp_rx;
        logic [1:0]    exp_ss;
        logic [2:0]    exp_ss3;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic cpol, input logic cpha, input logic [15:0] div,
                                input logic sel, input logic [1:0] sel3, input logic [DW-1:0] tx,
                                input logic [DW-1:0] miso, input logic [DW-1:0] exp_rx,
                                input logic [1:0] ss, input logic [2:0] ss3);
        vec_t v;
        v.cpol = cpol; v.cpha = cpha; v.div = div; v.sel = sel; v.sel3 = sel3;
        v.tx = tx; v.miso = miso; v.exp_rx = exp_rx; v.exp_ss = ss; v.exp_ss3 = ss3;
        return v;
    endfunction

    // MISO bit the slave must present during cycle c so that it has crossed the
    // two-flop synchroniser by the sample toggle it belongs to.
    function automatic logic next_miso(input vec_t v, input int c, input int h);
        for (int j = 0; j < DW; j++) begin
            if ((2 * j + 2 + int'(v.cpha)) * h >= c + 2) return v.miso[DW-1-j];
        end
        return 1'b0;
    endfunction

    task automatic do_frame(input vec_t v, input string tag);
        int h, len, bad_ss, bad_ss3, togs, early_rxv;
        logic prev_clk;
        logic [DW-1:0] mosi_word;
        h = int'(v.div) + 1;
        len = (2 * DW + 2) * h;
        bad_ss = 0; bad_ss3 = 0; togs = 0; early_rxv = 0; mosi_word = '0;
        @(negedge clk);
        cfg_div = v.div; cfg_cpol = v.cpol; cfg_cpha = v.cpha;
        cfg_ss_sel = v.sel; cfg_ss_sel3 = v.sel3; tx_data = v.tx; tx_valid = 1'b1;
        spi_miso = next_miso(v, 0, h);
        check({tag, "_tx_ready_idle"}, a_tx_ready, 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        prev_clk = v.cpol;
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            if (c == 1) check({tag, "_busy"}, a_busy, 1);
            if (c <= len) begin
                if (a_ss_n !== v.exp_ss) bad_ss++;
                if (b_ss_n !== v.exp_ss3) bad_ss3++;
                if (a_clk !== prev_clk) togs++;
                prev_clk = a_clk;
                if (a_rx_valid || b_rx_valid) early_rxv++;
                for (int j = 0; j < DW; j++)
                    if (c == (2 * j + 2 + int'(v.cpha)) * h) mosi_word[DW-1-j] = a_mosi;
            end else begin
                check({tag, "_ss_low_cycles_bad"}, bad_ss, 0);
                check({tag, "_ss3_low_cycles_bad"}, bad_ss3, 0);
                check({tag, "_toggles"}, togs, 2 * DW);
                check({tag, "_clk_end"}, prev_clk, v.cpol);
                check({tag, "_early_rx_valid"}, early_rxv, 0);
                check({tag, "_mosi"}, mosi_word, v.tx);
                check({tag, "_rx_valid"}, a_rx_valid, 1);
                check({tag, "_rx_valid3"}, b_rx_valid, 1);
                check({tag, "_rx_data"}, a_rx_data, v.exp_rx);
                check({tag, "_rx_data3"}, b_rx_data, v.exp_rx);
                check({tag, "_ss_release"}, {b_ss_n, a_ss_n}, 5'b11111);
                check({tag, "_idle_ready"}, {a_busy, a_tx_ready}, 2'b01);
            end
            spi_miso = next_miso(v, c, h);
        end
        @(negedge clk);
        check({tag, "_rx_valid_single"}, a_rx_valid, 0);
    endtask

    vec_t vecs[4];
    vec_t v_after_rst;

    initial begin
        int togs, rxv, ssbad, pulses, falls, gap, len;
        logic prev;
        logic [DW-1:0] mosi2;

`ifdef SPI_LOOPBACK_EN
        vecs[0] = mk(1'b0, 1'b0, 16'd1, 1'b1, 2'd2, 16'hBEEF, 16'h4110, 16'hBEEF, 2'b01, 3'b011);
        vecs[1] = mk(1'b0, 1'b1, 16'd0, 1'b0, 2'd0, 16'hBEEF, 16'h4110, 16'hBEEF, 2'b10, 3'b110);
        vecs[2] = mk(1'b1, 1'b0, 16'd2, 1'b0, 2'd3, 16'hBEEF, 16'h4110, 16'hBEEF, 2'b10, 3'b111);
        vecs[3] = mk(1'b1, 1'b1, 16'd0, 1'b1, 2'd1, 16'hBEEF, 16'h4110, 16'hBEEF, 2'b01, 3'b101);
        v_after_rst = mk(1'b0, 1'b0, 16'd1, 1'b1, 2'd2, 16'h5A5A, 16'h0000, 16'h5A5A, 2'b01, 3'b011);
`else
        vecs[0] = mk(1'b0, 1'b0, 16'd1, 1'b1, 2'd2, 8'hA5, 8'h3C, 8'h3C, 2'b01, 3'b011);
        vecs[1] = mk(1'b1, 1'b1, 16'd0, 1'b0, 2'd0, 8'h81, 8'hFF, 8'hFF, 2'b10, 3'b110);
        vecs[2] = mk(1'b0, 1'b1, 16'd2, 1'b0, 2'd3, 8'hC3, 8'h96, 8'h96, 2'b10, 3'b111);
        vecs[3] = mk(1'b1, 1'b0, 16'd0, 1'b1, 2'd1, 8'h5A, 8'h69, 8'h69, 2'b01, 3'b101);
        v_after_rst = mk(1'b0, 1'b0, 16'd1, 1'b1, 2'd2, 8'h5A, 8'hC6, 8'hC6, 2'b01, 3'b011);
`endif

        #2 resetn = 1'b0;
        #2;
        check("rst_ss_n", a_ss_n, 2'b11);
        check("rst_ss3_n", b_ss_n, 3'b111);
        check("rst_clk_mosi", {a_clk, a_mosi}, 2'b00);
        check("rst_rx_data", a_rx_data, 0);
        check("rst_rx_valid", a_rx_valid, 0);
        check("rst_busy_ready", {a_busy, a_tx_ready}, 2'b01);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 4; i++) do_frame(vecs[i], $sformatf("v%0d", i));

        // Abort a mode0 frame at its fifth toggle with an asynchronous reset.
        @(negedge clk);
        cfg_div = 16'd1; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_ss_sel = 1'b1; cfg_ss_sel3 = 2'd2;
        tx_data = '1; tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        togs = 0; prev = 1'b0;
        for (int c = 0; c < 200 && togs < 5; c++) begin
            @(negedge clk);
            if (a_clk !== prev) togs++;
            prev = a_clk;
        end
        check("abort_toggles_seen", togs, 5);
        check("abort_clk_before", a_clk, 1);
        #2 resetn = 1'b0;
        #1;
        check("abort_ss_n", {b_ss_n, a_ss_n}, 5'b11111);
        check("abort_clk", a_clk, 0);
        check("abort_busy", a_busy, 0);
        check("abort_rx_data", a_rx_data, 0);
        rxv = 0; ssbad = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_rx_valid || b_rx_valid) rxv++;
        end
        resetn = 1'b1;
        repeat (4 * (2 * DW + 2)) begin
            @(negedge clk);
            if (a_rx_valid || b_rx_valid) rxv++;
            if (a_ss_n !== 2'b11) ssbad++;
        end
        check("abort_no_rx_valid", rxv, 0);
        check("abort_ss_stays_high", ssbad, 0);
        do_frame(v_after_rst, "after_rst");

        // Back-to-back: tx_valid held high, second frame taken in the rx_valid cycle.
        len = 2 * DW + 2;
        spi_miso = 1'b0;
        @(negedge clk);
        cfg_div = 16'd0; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_ss_sel = 1'b0; cfg_ss_sel3 = 2'd0;
        tx_data = DW'(1); tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = DW'(2);
        pulses = 0; falls = 0; gap = 0; prev = 1'b1; mosi2 = '0;
        for (int c = 1; c <= 3 * len; c++) begin
            @(negedge clk);
            if (c == len + 1 + len / 2) tx_valid = 1'b0;
            if (a_rx_valid) pulses++;
            if (prev && !a_ss_n[0]) falls++;
            if (falls == 1 && a_ss_n[0]) gap++;
            prev = a_ss_n[0];
            for (int j = 0; j < DW; j++)
                if (c == len + 1 + 2 * j + 2) mosi2[DW-1-j] = a_mosi;
        end
        check("b2b_rx_valid_pulses", pulses, 2);
        check("b2b_frames", falls, 2);
        check("b2b_ss_gap", gap, 1);
        check("b2b_second_mosi", mosi2, DW'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
